// File: rtl/aes128_inv_round_ctrl.sv
// Iterative AES-128 decryption controller: one shared inverse round per clock,
// round keys fetched from an external expanded-key store, valid/ready result port.
module aes128_inv_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] ct_i,
  output logic [3:0]   rk_addr_o,
  input  logic [127:0] rk_data_i,
  output logic         busy_o,
  output logic [127:0] pt_o,
  output logic         pt_valid_o,
  input  logic         pt_ready_i
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned COL_W  = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned RND_W  = 4;

  localparam logic [RND_W-1:0] RK_INIT   = RND_W'(10);
  localparam logic [RND_W-1:0] RK_FINAL  = RND_W'(0);
  localparam logic [RND_W-1:0] RND_FIRST = RND_W'(9);
  localparam logic [RND_W-1:0] RND_LAST  = RND_W'(1);

  localparam logic [BYTE_W-1:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_HOLD
  } fsm_e;

  // GF(2^8) multiply-by-x with the AES reduction polynomial
  function automatic logic [BYTE_W-1:0] xt(input logic [BYTE_W-1:0] b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] mul9(input logic [BYTE_W-1:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [BYTE_W-1:0] mul11(input logic [BYTE_W-1:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [BYTE_W-1:0] mul13(input logic [BYTE_W-1:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [BYTE_W-1:0] mul14(input logic [BYTE_W-1:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  // Byte i = row (i%4), column (i/4); row r rotates right by r, then inverse S-box
  function automatic logic [BLK_W-1:0] inv_shift_sub(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[BLK_W-1-BYTE_W*(r+4*c) -: BYTE_W] =
          INV_SBOX[s[BLK_W-1-BYTE_W*(r+4*((c+4-r)%4)) -: BYTE_W]];
      end
    end
    return o;
  endfunction

  function automatic logic [COL_W-1:0] inv_mix_col(input logic [COL_W-1:0] a);
    logic [BYTE_W-1:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
            mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
            mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
            mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
  endfunction

  function automatic logic [BLK_W-1:0] inv_mix(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[BLK_W-1-COL_W*c -: COL_W] = inv_mix_col(s[BLK_W-1-COL_W*c -: COL_W]);
    end
    return o;
  endfunction

  fsm_e             fsm_q, fsm_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] pt_q, pt_d;
  logic             pt_valid_q, pt_valid_d;
  logic             busy_q, busy_d;
  logic [RND_W-1:0] rk_addr_c;
  logic [BLK_W-1:0] round_c;
  logic             accept_c;

  // Next-state, datapath select and key-address decode
  always_comb begin
    fsm_d      = fsm_q;
    rnd_d      = rnd_q;
    blk_d      = blk_q;
    pt_d       = pt_q;
    pt_valid_d = pt_valid_q;
    busy_d     = busy_q;
    rk_addr_c  = RK_INIT;
    accept_c   = 1'b0;
    round_c    = inv_shift_sub(blk_q) ^ rk_data_i;

    case (fsm_q)
      S_IDLE: begin
        accept_c = start_i;
      end
      S_ROUND: begin
        rk_addr_c = rnd_q;
        blk_d     = inv_mix(round_c);
        if (rnd_q == RND_LAST) begin
          fsm_d = S_FINAL;
        end else begin
          rnd_d = rnd_q - RND_W'(1);
        end
      end
      S_FINAL: begin
        rk_addr_c  = RK_FINAL;
        pt_d       = round_c;
        pt_valid_d = 1'b1;
        busy_d     = 1'b0;
        fsm_d      = S_HOLD;
      end
      S_HOLD: begin
        if (pt_ready_i) begin
          pt_valid_d = 1'b0;
          fsm_d      = S_IDLE;
          accept_c   = start_i;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase

    // Accept uses rk10, which the key store presents while idle or holding
    if (accept_c) begin
      blk_d  = ct_i ^ rk_data_i;
      rnd_d  = RND_FIRST;
      fsm_d  = S_ROUND;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= S_IDLE;
      rnd_q      <= '0;
      blk_q      <= '0;
      pt_q       <= '0;
      pt_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      rnd_q      <= rnd_d;
      blk_q      <= blk_d;
      pt_q       <= pt_d;
      pt_valid_q <= pt_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign rk_addr_o  = rk_addr_c;
  assign busy_o     = busy_q;
  assign pt_o       = pt_q;
  assign pt_valid_o = pt_valid_q;

endmodule

// File: tb/tb_aes128_inv_round_ctrl.sv
// Scoreboard bench for aes128_inv_round_ctrl: directed FIPS-197 C.1 scenarios
// plus randomized key/ciphertext traffic against a byte-level AES reference model.
module tb_aes128_inv_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [127:0] ct_i = '0;
  logic [3:0]   rk_addr_o;
  logic [127:0] rk_data_i;
  logic         busy_o;
  logic [127:0] pt_o;
  logic         pt_valid_o;
  logic         pt_ready_i = 1'b1;

  aes128_inv_round_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .ct_i       (ct_i),
    .rk_addr_o  (rk_addr_o),
    .rk_data_i  (rk_data_i),
    .busy_o     (busy_o),
    .pt_o       (pt_o),
    .pt_valid_o (pt_valid_o),
    .pt_ready_i (pt_ready_i)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  // External expanded-key store (combinational read)
  logic [127:0]  ks [16];
  logic [1407:0] cur_rks;
  assign rk_data_i = ks[rk_addr_o];

  logic [127:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] rk_sel(input logic [1407:0] rks, input int r);
    return rks[1407-128*r -: 128];
  endfunction

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] v;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    v = '0;
    for (int r = 0; r < 11; r++) v[1407-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return v;
  endfunction

  function automatic logic [7:0] mcoef(input int i);
    case (i)
      0: return 8'h0e;
      1: return 8'h0b;
      2: return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  // Textbook InvCipher on a 16-byte array
  function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [1407:0] rks);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   acc;
    logic [127:0] k, v;
    v = ct ^ rk_sel(rks, 10);
    for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*((c + r) % 4)] = s[r + 4*c];
      k = rk_sel(rks, rnd);
      for (int i = 0; i < 16; i++) s[i] = isbox[t[i]] ^ k[127-8*i -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(mcoef((j - r + 4) % 4), s[4*c + j]);
            t[4*c + r] = acc;
          end
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
    end
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
    return v;
  endfunction

  task automatic load_keys(input logic [127:0] key);
    cur_rks = expand_key(key);
    for (int r = 0; r < 11; r++) ks[r] = rk_sel(cur_rks, r);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic         hold_prev = 1'b0;
  logic [127:0] pt_prev = '0;

  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        check("valid_busy_exclusive", 128'(pt_valid_o & busy_o), 128'(0));
        if (hold_prev) begin
          check("hold_valid_stable", 128'(pt_valid_o), 128'(1));
          check("hold_pt_stable", pt_o, pt_prev);
        end
        if (pt_valid_o && pt_ready_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", pt_o, 128'(0));
            n_err += (pt_o == 128'(0)) ? 1 : 0;
          end else begin
            e = exp_q.pop_front();
            check("pt_result", pt_o, e);
          end
        end
        hold_prev = pt_valid_o && !pt_ready_i;
        pt_prev   = pt_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present start with ct in IDLE/HOLD; returns just after the accept edge E0
  task automatic launch(input logic [127:0] ct, input logic [127:0] exp);
    start_i    = 1'b1;
    ct_i       = ct;
    pt_ready_i = 1'b1;
    check("rk_addr_before_accept", 128'(rk_addr_o), 128'(10));
    exp_q.push_back(exp);
    step();
    start_i = 1'b0;
    ct_i    = rand128();
  endtask

  // Walk E1..E10 checking key addresses and status; optional busy-time start pulses
  task automatic track(input bit pulses, input bit stall);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("rk_addr_k%0d", k), 128'(rk_addr_o), 128'(9 - k));
      check("busy_in_round", 128'(busy_o), 128'(1));
      check("valid_in_round", 128'(pt_valid_o), 128'(0));
      if (pulses && (k == 2 || k == 9)) begin
        start_i = 1'b1;
        ct_i    = rand128();
      end else begin
        start_i = 1'b0;
      end
      if (stall && k == 9) pt_ready_i = 1'b0;
      step();
    end
    start_i = 1'b0;
    check("valid_after_e10", 128'(pt_valid_o), 128'(1));
    check("busy_after_e10", 128'(busy_o), 128'(0));
    check("rk_addr_hold", 128'(rk_addr_o), 128'(10));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 128'(pt_valid_o), 128'(0));
    check({tag, "_busy"}, 128'(busy_o), 128'(0));
    check({tag, "_rk_addr"}, 128'(rk_addr_o), 128'(10));
  endtask

  initial begin
    logic [127:0] ct2, key, ct;
    bit st, can;
    int issued, cycles, waits;

    for (int i = 0; i < 16; i++) ks[i] = '0;
    init_sbox();
    load_keys(C1_KEY);

    // Reset values before any clock edge
    #1;
    check("reset_pt", pt_o, 128'(0));
    check_idle("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // C.1 vector with exact latency and key-address sequence
    launch(C1_CT, C1_PT);
    track(1'b0, 1'b0);
    step();
    check_idle("c1_done");

    // Start pulses at E3 and E10 must be ignored
    launch(C1_CT, C1_PT);
    track(1'b1, 1'b0);
    step();
    check_idle("busy_start_done");
    step();
    check_idle("busy_start_idle");

    // Back-pressure: five stalled cycles with a start pulse in HOLD
    launch(C1_CT, C1_PT);
    track(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 128'(pt_valid_o), 128'(1));
      check("bp_pt", pt_o, C1_PT);
      start_i = (i == 2);
      ct_i    = rand128();
      step();
    end
    start_i    = 1'b0;
    pt_ready_i = 1'b1;
    step();
    check_idle("bp_release");
    step();
    check_idle("bp_ignored_start");

    // Back-to-back: consume and accept in the same HOLD cycle
    launch(C1_CT, C1_PT);
    track(1'b0, 1'b0);
    ct2 = rand128();
    launch(ct2, aes_dec(ct2, cur_rks));
    track(1'b0, 1'b0);
    step();
    check_idle("b2b_done");

    // Asynchronous reset between E5 and E6
    launch(C1_CT, C1_PT);
    for (int i = 0; i < 5; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_pt", pt_o, 128'(0));
    check_idle("midreset");
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    launch(C1_CT, C1_PT);
    track(1'b0, 1'b0);
    step();
    check_idle("post_reset_done");

    // Randomized traffic with stalls and ignored starts
    issued = 0;
    cycles = 0;
    while (issued < 200 && cycles < 30000) begin
      pt_ready_i = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 2) == 0);
      can = !busy_o && (!pt_valid_o || pt_ready_i);
      if (st && can) begin
        key = rand128();
        ct  = rand128();
        load_keys(key);
        exp_q.push_back(aes_dec(ct, cur_rks));
        issued++;
      end else begin
        ct = rand128();
      end
      start_i = st;
      ct_i    = ct;
      step();
      cycles++;
    end
    start_i = 1'b0;
    check("random_blocks_issued", 128'(issued), 128'(200));

    pt_ready_i = 1'b1;
    waits = 0;
    while (exp_q.size() != 0 && waits < 60) begin
      step();
      waits++;
    end
    check("results_outstanding", 128'(exp_q.size()), 128'(0));
    step();
    check_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
